rejudge_entry: RTL and testbench
================================

REJUDGE_ENTRY -- requirements
Module: rejudge_entry

Interface
REQ-001 Parameter DEB_CYCLES, default 20: consecutive stable cycles for a button level change to be accepted.
REQ-002 Parameter MAX_SCORE, default 99: highest enterable score.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn_up  input  1  raw, asynchronous push-button; increments the active field.
REQ-006 btn_down  input  1  raw push-button; decrements the active field.
REQ-007 btn_next  input  1  raw push-button; advances to the next field, or confirms.
REQ-008 btn_cancel  input  1  raw push-button; aborts entry.
REQ-009 cmd_ready  input  1  consumer accepts the command.
REQ-010 player  output  2  selected player index (0..3); the display adds 1.
REQ-011 problemID  output  8  selected problem, binary 0..99.
REQ-012 score  output  8  new score, binary 0..MAX_SCORE.
REQ-013 field_sel  output  2  field being edited: 0 player, 1 problem, 2 score, 3 confirm/issue.
REQ-014 cmd_valid  output  1  rejudge command pending.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer followed by a debouncer, one per button.
REQ-016 Debounced level SHALL change only after the synchronized level has differed from it for DEB_CYCLES consecutive cycles; any earlier reversion SHALL reset the count.
REQ-017 A debounced 0->1 transition SHALL produce a one-cycle press pulse; a held button SHALL produce no further pulses; release SHALL produce none.
REQ-018 Latency: the field or state update SHALL be visible on outputs exactly DEB_CYCLES+4 rising edges after a clean raw 0->1 edge.
REQ-019 FSM states: S_PLAYER, S_PROBLEM, S_SCORE, S_CONFIRM, S_ISSUE; field_sel SHALL be 0, 1, 2, 3, 3 respectively.
REQ-020 Same-cycle pulses SHALL be resolved by priority cancel > next > up > down; only the winner SHALL act.
REQ-021 up/down in S_PLAYER, S_PROBLEM and S_SCORE SHALL modify only that field, by +/-1.
REQ-022 Wrap-around: player 3+1 -> 0 and 0-1 -> 3; problemID 99+1 -> 0 and 0-1 -> 99; score MAX_SCORE+1 -> 0 and 0-1 -> MAX_SCORE.
REQ-023 next SHALL advance the state S_PLAYER -> S_PROBLEM -> S_SCORE -> S_CONFIRM -> S_ISSUE.
REQ-024 up/down SHALL be ignored in S_CONFIRM and S_ISSUE.
REQ-025 cancel in S_PLAYER through S_CONFIRM SHALL clear all three fields to 0 and go to S_PLAYER.
REQ-026 S_ISSUE: cmd_valid=1, and player/problemID/score SHALL be held constant.
REQ-027 In S_ISSUE, all buttons, including cancel, SHALL be ignored until the handshake completes.
REQ-028 Handshake: when cmd_valid && cmd_ready on an edge, the next cycle SHALL have cmd_valid=0 and state S_PLAYER, with field values retained.
REQ-029 cmd_ready while not in S_ISSUE SHALL have no effect.
REQ-030 cmd_valid SHALL be 1 only in S_ISSUE and SHALL never drop before the handshake.

Reset
REQ-031 rst sampled high SHALL set state S_PLAYER, player=0, problemID=0, score=0, field_sel=0, cmd_valid=0.
REQ-032 rst sampled high SHALL clear all synchronizer flops, debounce counters and debounced levels to 0.
REQ-033 Reset SHALL take priority over every other event, including a pending handshake, and SHALL abort an issuing command with no completion.
REQ-034 A button held high through reset release SHALL generate exactly one press once debounced.

Verification
REQ-035 DEB_CYCLES=4: press up cleanly in S_PLAYER -> player 0->1 exactly 8 edges after the raw edge; hold 50 cycles -> no further change.
REQ-036 Bounce up as 1,0,1 with 2-cycle glitches, then steady high -> player increments exactly once.
REQ-037 Enter player 2, problem 99+1, score 0-1 -> problemID=0, score=99; next in S_SCORE reaches S_CONFIRM; next again gives cmd_valid=1 carrying (2, 0, 99).
REQ-038 In S_ISSUE hold cmd_ready=0 for 10 cycles while pressing cancel and up -> cmd_valid stays 1 and outputs are unchanged; cmd_ready=1 for 1 cycle -> cmd_valid=0 and field_sel=0 next cycle.
REQ-039 Press cancel and next in the same cycle while in S_SCORE -> fields become 0 and state S_PLAYER.
REQ-040 Assert rst during S_ISSUE -> all outputs reach their reset values on the next edge.

Source files
------------

// File: rtl/rejudge_entry_if.sv
// Button inputs, command handshake and field outputs of the rejudge entry panel.
// The master modport is the entry logic; the slave modport is the panel/consumer side.
interface rejudge_entry_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_next;
  logic       btn_cancel;
  logic       cmd_ready;
  logic [1:0] player;
  logic [7:0] problemID;
  logic [7:0] score;
  logic [1:0] field_sel;
  logic       cmd_valid;

  modport master (
    input  btn_up, btn_down, btn_next, btn_cancel, cmd_ready,
    output player, problemID, score, field_sel, cmd_valid
  );

  modport slave (
    output btn_up, btn_down, btn_next, btn_cancel, cmd_ready,
    input  player, problemID, score, field_sel, cmd_valid
  );
endinterface

// File: rtl/rejudge_entry.sv
// Four-button rejudge entry: synchronise and debounce buttons, edit player/problem/score, issue command.
// Press-to-output latency DEB_CYCLES+4 edges; command held with cmd_valid until cmd_ready, inputs ignored meanwhile.
module rejudge_entry #(
  parameter int DEB_CYCLES = 20,
  parameter int MAX_SCORE  = 99
) (
  input  logic clk,
  input  logic rst,
  rejudge_entry_if.master bus
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [7:0]    SCORE_MAX = 8'(MAX_SCORE);
  localparam logic [7:0]    PROB_MAX  = 8'd99;

  // Button bit order: 0 cancel, 1 next, 2 up, 3 down (also the priority order).
  localparam int B_CANCEL = 0;
  localparam int B_NEXT   = 1;
  localparam int B_UP     = 2;
  localparam int B_DOWN   = 3;

  typedef enum logic [2:0] {
    S_PLAYER  = 3'd0,
    S_PROBLEM = 3'd1,
    S_SCORE   = 3'd2,
    S_CONFIRM = 3'd3,
    S_ISSUE   = 3'd4
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    deb_q, deb_d, deb_prev_q;
  logic [3:0]    press_q, press_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  state_t     state_q, state_d;
  logic [1:0] player_q, player_d;
  logic [7:0] problem_q, problem_d;
  logic [7:0] score_q, score_d;

  assign raw = {bus.btn_down, bus.btn_up, bus.btn_next, bus.btn_cancel};

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    press_d = deb_q & ~deb_prev_q;
  end

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    problem_d = problem_q;
    score_d   = score_q;
    if (state_q == S_ISSUE) begin
      if (bus.cmd_ready) state_d = S_PLAYER;
    end else if (press_q[B_CANCEL]) begin
      state_d   = S_PLAYER;
      player_d  = '0;
      problem_d = '0;
      score_d   = '0;
    end else if (press_q[B_NEXT]) begin
      case (state_q)
        S_PLAYER:  state_d = S_PROBLEM;
        S_PROBLEM: state_d = S_SCORE;
        S_SCORE:   state_d = S_CONFIRM;
        default:   state_d = S_ISSUE;
      endcase
    end else if (press_q[B_UP]) begin
      case (state_q)
        S_PLAYER:  player_d  = player_q + 2'd1;
        S_PROBLEM: problem_d = (problem_q == PROB_MAX) ? 8'd0 : problem_q + 8'd1;
        S_SCORE:   score_d   = (score_q == SCORE_MAX) ? 8'd0 : score_q + 8'd1;
        default:   ;
      endcase
    end else if (press_q[B_DOWN]) begin
      case (state_q)
        S_PLAYER:  player_d  = player_q - 2'd1;
        S_PROBLEM: problem_d = (problem_q == 8'd0) ? PROB_MAX : problem_q - 8'd1;
        S_SCORE:   score_d   = (score_q == 8'd0) ? SCORE_MAX : score_q - 8'd1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      cnt_q      <= '{default: '0};
      state_q    <= S_PLAYER;
      player_q   <= '0;
      problem_q  <= '0;
      score_q    <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      press_q    <= press_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      player_q   <= player_d;
      problem_q  <= problem_d;
      score_q    <= score_d;
    end
  end

  assign bus.player    = player_q;
  assign bus.problemID = problem_q;
  assign bus.score     = score_q;
  assign bus.field_sel = (state_q == S_ISSUE) ? 2'd3 : state_q[1:0];
  assign bus.cmd_valid = (state_q == S_ISSUE);

endmodule

// File: tb/tb_rejudge_entry.sv
// Directed and randomised checks of rejudge_entry against a press-level model of the entry panel.
module tb_rejudge_entry;
  localparam int DEB  = 4;
  localparam int MAXS = 99;
  localparam int HOLD = DEB + 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  // Model: field values and state (0 player, 1 problem, 2 score, 3 confirm, 4 issue).
  int m_player, m_prob, m_score, m_state;

  rejudge_entry_if bus ();
  rejudge_entry #(.DEB_CYCLES(DEB), .MAX_SCORE(MAXS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".player"},    int'(bus.player),    m_player);
    check({tag, ".problemID"}, int'(bus.problemID), m_prob);
    check({tag, ".score"},     int'(bus.score),     m_score);
    check({tag, ".field_sel"}, int'(bus.field_sel), (m_state == 4) ? 3 : m_state);
    check({tag, ".cmd_valid"}, int'(bus.cmd_valid), (m_state == 4) ? 1 : 0);
  endtask

  function automatic void model_reset();
    m_player = 0; m_prob = 0; m_score = 0; m_state = 0;
  endfunction

  // mask bits: 0 cancel, 1 next, 2 up, 3 down
  function automatic void model_press(input logic [3:0] mask);
    int step;
    if (m_state == 4) return;
    if (mask[0]) begin
      model_reset();
    end else if (mask[1]) begin
      m_state = m_state + 1;
    end else if (m_state < 3 && (mask[2] || mask[3])) begin
      step = mask[2] ? 1 : -1;
      case (m_state)
        0: m_player = (m_player + step + 4) % 4;
        1: m_prob   = (m_prob + step + 100) % 100;
        default: m_score = (m_score + step + MAXS + 1) % (MAXS + 1);
      endcase
    end
  endfunction

  task automatic set_btns(input logic [3:0] mask);
    bus.btn_cancel = mask[0];
    bus.btn_next   = mask[1];
    bus.btn_up     = mask[2];
    bus.btn_down   = mask[3];
  endtask

  task automatic press(input logic [3:0] mask, input string tag);
    set_btns(mask);
    repeat (HOLD) @(negedge clk);
    set_btns(4'b0000);
    repeat (HOLD) @(negedge clk);
    model_press(mask);
    check_all(tag);
  endtask

  task automatic handshake(input string tag);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    if (m_state == 4) m_state = 0;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] mask;
    set_btns(4'b0000);
    bus.cmd_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Clean press: exact latency, then long hold gives nothing more.
    @(negedge clk);
    bus.btn_up = 1'b1;
    repeat (DEB + 3) @(negedge clk);
    check("lat_before", int'(bus.player), 0);
    @(negedge clk);
    check("lat_exact", int'(bus.player), 1);
    repeat (50) @(negedge clk);
    check("hold_no_repeat", int'(bus.player), 1);
    bus.btn_up = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("release_no_press", int'(bus.player), 1);
    m_player = 1;

    // Bouncing press counts once.
    bus.btn_up = 1'b1; repeat (2) @(negedge clk);
    bus.btn_up = 1'b0; repeat (2) @(negedge clk);
    bus.btn_up = 1'b1; repeat (2) @(negedge clk);
    bus.btn_up = 1'b0; repeat (2) @(negedge clk);
    bus.btn_up = 1'b1; repeat (20) @(negedge clk);
    bus.btn_up = 1'b0; repeat (HOLD) @(negedge clk);
    check("bounce_once", int'(bus.player), 2);
    m_player = 2;

    // Wrap-around entry and issue of (2, 0, 99).
    press(4'b0010, "to_problem");
    press(4'b1000, "prob_down_wrap");
    check("prob_99", int'(bus.problemID), 99);
    press(4'b0100, "prob_up_wrap");
    check("prob_0", int'(bus.problemID), 0);
    press(4'b0010, "to_score");
    press(4'b1000, "score_down_wrap");
    check("score_99", int'(bus.score), 99);
    press(4'b0010, "to_confirm");
    check("confirm_sel", int'(bus.field_sel), 3);
    press(4'b1000, "confirm_ignores_down");
    press(4'b0010, "to_issue");
    check("issue_valid", int'(bus.cmd_valid), 1);

    // Buttons ignored while issuing, then handshake.
    press(4'b0001, "issue_cancel_ignored");
    press(4'b0100, "issue_up_ignored");
    handshake("handshake");
    check("hs_player_kept", int'(bus.player), 2);
    handshake("ready_idle_no_effect");

    // Cancel beats next in the same cycle.
    press(4'b0010, "c_to_problem");
    press(4'b0010, "c_to_score");
    press(4'b0011, "cancel_next_same");
    check("cancel_score0", int'(bus.score), 0);

    // Reset during issue, with up held through reset release.
    press(4'b0100, "r_up");
    for (int i = 0; i < 4; i++) press(4'b0010, "r_next");
    check("r_issue", int'(bus.cmd_valid), 1);
    rst = 1'b1;
    bus.btn_up = 1'b1;
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    model_reset();
    check_all("rst_in_issue");
    bus.cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (DEB + 10) @(negedge clk);
    check("held_through_rst", int'(bus.player), 1);
    repeat (30) @(negedge clk);
    check("held_through_rst_once", int'(bus.player), 1);
    bus.btn_up = 1'b0;
    repeat (HOLD) @(negedge clk);
    m_player = 1;
    check_all("post_rst_hold");

    // Random presses, button combinations and handshakes.
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        handshake("rand_hs");
      end else begin
        if ($urandom_range(0, 3) == 0) mask = 4'($urandom_range(1, 15));
        else mask = 4'(1 << $urandom_range(0, 3));
        press(mask, "rand_press");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
